multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, setting the width of each performance counter.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port Instruction, input, 32: instruction memory output; opcode [31:26], funct [5:0].
REQ-005 SHALL have port MemAck, input, 1: data-memory access complete.
REQ-006 SHALL have ports PCWr, IRWr, RegWr, MemReq and MemWr, each output, 1: strobes for PC, instruction register, register file, memory request and memory write.
REQ-007 SHALL have ports MemToReg, Branch, Jump, JumpReg, InvZero and ExtendMethod, each output, 1: datapath selects.
REQ-008 SHALL have ports ALUsrc, output, 2 (0 imm32, 1 PCBuff, 2 Db), and RegDst, output, 2 (0 rt, 1 rd, 2 r31).
REQ-009 SHALL have port ALUcntrl, output, 3, encoded ADD=0, SUB=1, XOR=2, SLT=3.
REQ-010 SHALL have ports state, output, 3, and halted, output, 1.
REQ-011 SHALL have ports cycle_count and instr_count, each output, CNT_W.

Function
REQ-012 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and HALT=5.
- State register drives state.
- Outputs are a function of state and a latched opcode/funct register only (Moore).
REQ-013 FETCH SHALL assert IRWr and PCWr, latch Instruction[31:26] and [5:0] internally, and go to DECODE.
REQ-014 DECODE SHALL go to EXEC for supported opcodes (R-type funct 0x20/0x22/0x2A/0x08, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, XORI 0x0E, J 0x02, JAL 0x03), else to HALT.
REQ-015 EXEC SHALL drive per class, then go to the next state shown:
- R-type: ALUsrc=2, ALUcntrl by funct (ADD/SUB/SLT) -> WB.
- XORI: ALUsrc=0, ExtendMethod=1, XOR -> WB.
- LW/SW: ALUsrc=0, ExtendMethod=0, ADD -> MEM.
- BEQ/BNE: ALUsrc=2, SUB, Branch=1, PCWr=1, InvZero=1 only for BNE -> FETCH.
- J: Jump=1, PCWr=1 -> FETCH.
- JAL: Jump=1, PCWr=1, RegWr=1, RegDst=2, ALUsrc=1 -> FETCH.
- JR: JumpReg=1, PCWr=1 -> FETCH.
REQ-016 MEM SHALL hold MemReq=1 (MemWr=1 for SW) every cycle until MemAck is sampled high.
- On ack: LW -> WB, SW -> FETCH.
- MemAck outside MEM is ignored.
REQ-017 WB SHALL assert RegWr for one cycle and go to FETCH.
- RegDst=1 for R-type, 0 for XORI/LW; MemToReg=1 only for LW.
REQ-018 ALU selects SHALL hold their EXEC values through MEM and WB of the same instruction.
REQ-019 Instruction latency SHALL be:
- 3 cycles: branch, J, JAL, JR.
- 4 cycles: R-type, XORI.
- 4+w cycles: SW, where w = extra MEM wait cycles.
- 5+w cycles: LW.
REQ-020 HALT SHALL deassert every strobe, set halted=1, and remain until reset.
REQ-021 Every strobe not explicitly listed for a state SHALL be 0 in that state.

Reset
REQ-022 Reset SHALL force state=FETCH, all strobes and selects to 0, halted=0, and the latched opcode/funct to 0, on the next rising edge.
REQ-023 Reset SHALL take priority in every state, including mid-MEM; MemReq is 0 in the first cycle after reset.
REQ-024 Reset SHALL clear both counters to 0 when compiled in.

Configuration
REQ-025 With macro MC_PERF_CNT_EN defined, counters SHALL operate as follows:
- cycle_count increments every non-reset cycle, including HALT.
- instr_count increments on each transition into FETCH from EXEC, MEM or WB.
- Both wrap modulo 2^CNT_W.
REQ-026 Without MC_PERF_CNT_EN, cycle_count and instr_count SHALL be constant 0 and no counter flops are synthesized.

Verification
REQ-027 Reset, then ADD (opcode 0, funct 0x20) -> states 0,1,2,4,0; RegWr=1 only in WB with RegDst=1; instr_count=1.
REQ-028 LW (0x23) with MemAck delayed 3 cycles -> MemReq high 4 cycles, then WB with MemToReg=1; total 8 cycles.
REQ-029 BNE (0x05) -> EXEC shows Branch=1, InvZero=1, PCWr=1, ALUcntrl=1; back in FETCH after 3 cycles.
REQ-030 Opcode 0x3F -> HALT after DECODE, halted=1 for 10 cycles, all strobes 0; reset returns state to FETCH.
REQ-031 SW with reset asserted in the second MEM cycle -> MemReq=0 and state=0 the next cycle; counters=0 with MC_PERF_CNT_EN, always 0 without it.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for a multicycle MIPS-subset datapath.
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, with HALT on unsupported
// opcodes. Outputs are registered: they are computed from the next state and
// the next latched opcode/funct, so they always line up with the state output.
// Optional performance counters are enabled with the macro MC_PERF_CNT_EN.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instruction,
    input  logic             MemAck,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RegWr,
    output logic             MemReq,
    output logic             MemWr,
    output logic             MemToReg,
    output logic             Branch,
    output logic             Jump,
    output logic             JumpReg,
    output logic             InvZero,
    output logic             ExtendMethod,
    output logic [1:0]       ALUsrc,
    output logic [1:0]       RegDst,
    output logic [2:0]       ALUcntrl,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R    = 4'd0,
        C_XORI = 4'd1,
        C_LW   = 4'd2,
        C_SW   = 4'd3,
        C_BR   = 4'd4,
        C_J    = 4'd5,
        C_JAL  = 4'd6,
        C_JR   = 4'd7,
        C_BAD  = 4'd8
    } cls_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    // Map an opcode/funct pair onto the instruction class driving the FSM.
    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
        cls_t c;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h22, 6'h2A: c = C_R;
                    6'h08:               c = C_JR;
                    default:             c = C_BAD;
                endcase
            end
            6'h23:        c = C_LW;
            6'h2B:        c = C_SW;
            6'h04, 6'h05: c = C_BR;
            6'h0E:        c = C_XORI;
            6'h02:        c = C_J;
            6'h03:        c = C_JAL;
            default:      c = C_BAD;
        endcase
        return c;
    endfunction

    // ALU operation for the arithmetic R-type functs.
    function automatic logic [2:0] alu_of_funct(input logic [5:0] fn);
        logic [2:0] a;
        case (fn)
            6'h22:   a = ALU_SUB;
            6'h2A:   a = ALU_SLT;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] fn_q, fn_d;
    cls_t       cls_q, cls_d;

    logic       pcwr_q, pcwr_d, irwr_q, irwr_d, regwr_q, regwr_d;
    logic       memreq_q, memreq_d, memwr_q, memwr_d, memtoreg_q, memtoreg_d;
    logic       branch_q, branch_d, jump_q, jump_d, jumpreg_q, jumpreg_d;
    logic       invzero_q, invzero_d, ext_q, ext_d, halted_q, halted_d;
    logic [1:0] alusrc_q, alusrc_d, regdst_q, regdst_d;
    logic [2:0] aluc_q, aluc_d;

    // Only opcode and funct are consumed; the operand fields belong to the datapath.
    logic unused_instr_s;
    assign unused_instr_s = ^Instruction[25:6];

    assign cls_q = classify(op_q, fn_q);
    assign cls_d = classify(op_d, fn_d);

    // Next-state logic and opcode/funct latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fn_d    = fn_q;
        case (state_q)
            S_FETCH: begin
                op_d    = Instruction[31:26];
                fn_d    = Instruction[5:0];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (cls_q == C_BAD) state_d = S_HALT;
                else                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    C_R, C_XORI: state_d = S_WB;
                    C_LW, C_SW:  state_d = S_MEM;
                    default:     state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (MemAck) begin
                    if (cls_q == C_LW) state_d = S_WB;
                    else               state_d = S_FETCH;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Output decode for the state being entered, so outputs can be registered.
    always_comb begin
        pcwr_d = 1'b0; irwr_d = 1'b0; regwr_d = 1'b0; memreq_d = 1'b0;
        memwr_d = 1'b0; memtoreg_d = 1'b0; branch_d = 1'b0; jump_d = 1'b0;
        jumpreg_d = 1'b0; invzero_d = 1'b0; ext_d = 1'b0; halted_d = 1'b0;
        alusrc_d = 2'd0; regdst_d = 2'd0; aluc_d = ALU_ADD;
        // ALU selects are set for EXEC and held through MEM/WB of the same instruction.
        if (state_d == S_EXEC || state_d == S_MEM || state_d == S_WB) begin
            case (cls_d)
                C_R:  begin alusrc_d = 2'd2; aluc_d = alu_of_funct(fn_d); end
                C_XORI: begin alusrc_d = 2'd0; ext_d = 1'b1; aluc_d = ALU_XOR; end
                C_LW, C_SW: begin alusrc_d = 2'd0; ext_d = 1'b0; aluc_d = ALU_ADD; end
                default: begin alusrc_d = 2'd0; aluc_d = ALU_ADD; end
            endcase
        end else begin
            alusrc_d = 2'd0;
        end
        case (state_d)
            S_FETCH: begin
                irwr_d = 1'b1;
                pcwr_d = 1'b1;
            end
            S_EXEC: begin
                case (cls_d)
                    C_BR: begin
                        alusrc_d  = 2'd2;
                        aluc_d    = ALU_SUB;
                        branch_d  = 1'b1;
                        pcwr_d    = 1'b1;
                        invzero_d = (op_d == 6'h05);
                    end
                    C_J: begin
                        jump_d = 1'b1;
                        pcwr_d = 1'b1;
                    end
                    C_JAL: begin
                        jump_d   = 1'b1;
                        pcwr_d   = 1'b1;
                        regwr_d  = 1'b1;
                        regdst_d = 2'd2;
                        alusrc_d = 2'd1;
                    end
                    C_JR: begin
                        jumpreg_d = 1'b1;
                        pcwr_d    = 1'b1;
                    end
                    default: begin
                        pcwr_d = 1'b0;
                    end
                endcase
            end
            S_MEM: begin
                memreq_d = 1'b1;
                memwr_d  = (cls_d == C_SW);
            end
            S_WB: begin
                regwr_d    = 1'b1;
                regdst_d   = (cls_d == C_R) ? 2'd1 : 2'd0;
                memtoreg_d = (cls_d == C_LW);
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                halted_d = 1'b0;
            end
        endcase
    end

    // State, latched instruction fields and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH; op_q <= 6'd0; fn_q <= 6'd0;
            pcwr_q <= 1'b0; irwr_q <= 1'b0; regwr_q <= 1'b0; memreq_q <= 1'b0;
            memwr_q <= 1'b0; memtoreg_q <= 1'b0; branch_q <= 1'b0; jump_q <= 1'b0;
            jumpreg_q <= 1'b0; invzero_q <= 1'b0; ext_q <= 1'b0; halted_q <= 1'b0;
            alusrc_q <= 2'd0; regdst_q <= 2'd0; aluc_q <= 3'd0;
        end else begin
            state_q <= state_d; op_q <= op_d; fn_q <= fn_d;
            pcwr_q <= pcwr_d; irwr_q <= irwr_d; regwr_q <= regwr_d; memreq_q <= memreq_d;
            memwr_q <= memwr_d; memtoreg_q <= memtoreg_d; branch_q <= branch_d; jump_q <= jump_d;
            jumpreg_q <= jumpreg_d; invzero_q <= invzero_d; ext_q <= ext_d; halted_q <= halted_d;
            alusrc_q <= alusrc_d; regdst_q <= regdst_d; aluc_q <= aluc_d;
        end
    end

    assign state        = state_q;
    assign PCWr         = pcwr_q;
    assign IRWr         = irwr_q;
    assign RegWr        = regwr_q;
    assign MemReq       = memreq_q;
    assign MemWr        = memwr_q;
    assign MemToReg     = memtoreg_q;
    assign Branch       = branch_q;
    assign Jump         = jump_q;
    assign JumpReg      = jumpreg_q;
    assign InvZero      = invzero_q;
    assign ExtendMethod = ext_q;
    assign ALUsrc       = alusrc_q;
    assign RegDst       = regdst_q;
    assign ALUcntrl     = aluc_q;
    assign halted       = halted_q;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, ins_q;
    logic             retire_s;

    // An instruction retires whenever EXEC, MEM or WB hands control back to FETCH.
    assign retire_s = ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB))
                      && (state_d == S_FETCH);

    // Free-running cycle counter and retired-instruction counter, both wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= {CNT_W{1'b0}};
            ins_q <= {CNT_W{1'b0}};
        end else begin
            cyc_q <= cyc_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (retire_s) ins_q <= ins_q + {{(CNT_W-1){1'b0}}, 1'b1};
            else          ins_q <= ins_q;
        end
    end

    assign cycle_count = cyc_q;
    assign instr_count = ins_q;
`else
    assign cycle_count = {CNT_W{1'b0}};
    assign instr_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A per-instruction trace model
// builds the expected cycle-by-cycle output record from the instruction
// class rules; random instructions, wait states and stray MemAck are applied.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instruction;
    logic        MemAck;
    logic        PCWr, IRWr, RegWr, MemReq, MemWr, MemToReg, Branch, Jump, JumpReg;
    logic        InvZero, ExtendMethod, halted;
    logic [1:0]  ALUsrc, RegDst;
    logic [2:0]  ALUcntrl, state;
    logic [31:0] cycle_count, instr_count;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Instruction(Instruction), .MemAck(MemAck),
        .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemReq(MemReq), .MemWr(MemWr),
        .MemToReg(MemToReg), .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg),
        .InvZero(InvZero), .ExtendMethod(ExtendMethod), .ALUsrc(ALUsrc),
        .RegDst(RegDst), .ALUcntrl(ALUcntrl), .state(state), .halted(halted),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    typedef struct packed {
        logic [2:0] st;
        logic pcwr, irwr, regwr, memreq, memwr, memtoreg, branch, jump, jumpreg, invzero, ext;
        logic [1:0] alusrc, regdst;
        logic [2:0] aluc;
        logic halted;
    } rec_t;

    rec_t act_s;
    assign act_s = {state, PCWr, IRWr, RegWr, MemReq, MemWr, MemToReg, Branch, Jump,
                    JumpReg, InvZero, ExtendMethod, ALUsrc, RegDst, ALUcntrl, halted};

    int          vectors = 0;
    int          errors  = 0;
    int unsigned cyc_m   = 0;
    int unsigned ins_m   = 0;
    bit          first_m = 1'b1;
    rec_t        exp_q[$];

    function automatic rec_t blank(input logic [2:0] s);
        rec_t r;
        r    = '0;
        r.st = s;
        return r;
    endfunction

    function automatic int unsigned exp_cyc();
`ifdef MC_PERF_CNT_EN
        return cyc_m;
`else
        return 32'd0;
`endif
    endfunction

    function automatic int unsigned exp_ins();
`ifdef MC_PERF_CNT_EN
        return ins_m;
`else
        return 32'd0;
`endif
    endfunction

    // One clock; the model's cycle/instruction counts follow the reset seen at the edge.
    task automatic step();
        bit r;
        r = reset;
        @(posedge clk);
        #1;
        if (r) begin
            cyc_m = 0;
            ins_m = 0;
        end else begin
            cyc_m = cyc_m + 1;
        end
    endtask

    // Expected trace for one instruction, from fetch to the cycle before the next fetch.
    task automatic build_trace(input logic [5:0] op, input logic [5:0] fn, input int w,
                               output bit halts);
        rec_t r, ex, wb;
        exp_q.delete();
        halts = 1'b0;
        r = blank(3'd0);
        if (!first_m) begin r.pcwr = 1'b1; r.irwr = 1'b1; end
        exp_q.push_back(r);
        exp_q.push_back(blank(3'd1));
        ex = blank(3'd2);
        wb = blank(3'd4);
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) begin
            ex.alusrc = 2'd2;
            ex.aluc = (fn == 6'h20) ? 3'd0 : (fn == 6'h22) ? 3'd1 : 3'd3;
            wb = ex; wb.st = 3'd4; wb.regwr = 1'b1; wb.regdst = 2'd1;
            exp_q.push_back(ex); exp_q.push_back(wb);
        end else if (op == 6'h00 && fn == 6'h08) begin
            ex.jumpreg = 1'b1; ex.pcwr = 1'b1;
            exp_q.push_back(ex);
        end else if (op == 6'h0E) begin
            ex.ext = 1'b1; ex.aluc = 3'd2;
            wb = ex; wb.st = 3'd4; wb.regwr = 1'b1;
            exp_q.push_back(ex); exp_q.push_back(wb);
        end else if (op == 6'h23 || op == 6'h2B) begin
            exp_q.push_back(ex);
            for (int k = 0; k <= w; k++) begin
                r = ex; r.st = 3'd3; r.memreq = 1'b1; r.memwr = (op == 6'h2B);
                exp_q.push_back(r);
            end
            if (op == 6'h23) begin
                wb = ex; wb.st = 3'd4; wb.regwr = 1'b1; wb.memtoreg = 1'b1;
                exp_q.push_back(wb);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            ex.alusrc = 2'd2; ex.aluc = 3'd1; ex.branch = 1'b1; ex.pcwr = 1'b1;
            ex.invzero = (op == 6'h05);
            exp_q.push_back(ex);
        end else if (op == 6'h02) begin
            ex.jump = 1'b1; ex.pcwr = 1'b1;
            exp_q.push_back(ex);
        end else if (op == 6'h03) begin
            ex.jump = 1'b1; ex.pcwr = 1'b1; ex.regwr = 1'b1; ex.regdst = 2'd2; ex.alusrc = 2'd1;
            exp_q.push_back(ex);
        end else begin
            halts = 1'b1;
            for (int k = 0; k < 10; k++) begin
                r = blank(3'd5); r.halted = 1'b1;
                exp_q.push_back(r);
            end
        end
    endtask

    // Apply one instruction and compare every cycle; optionally assert reset at cycle reset_at.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int w,
                             input int reset_at);
        bit halts;
        int mem_i;
        int n;
        logic [31:0] rnd;
        rec_t e;
        build_trace(op, fn, w, halts);
        mem_i = 0;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            e = exp_q[i];
            vectors++;
            if (act_s !== e) begin
                errors++;
                $display("FAIL trace op=%h fn=%h cyc %0d: got %h expected %h", op, fn, i, act_s, e);
            end
            vectors++;
            if (cycle_count !== exp_cyc() || instr_count !== exp_ins()) begin
                errors++;
                $display("FAIL counters op=%h cyc %0d: got %0d/%0d expected %0d/%0d",
                         op, i, cycle_count, instr_count, exp_cyc(), exp_ins());
            end
            rnd = $urandom();
            if (i == 0) Instruction = {op, rnd[25:6], fn};
            else        Instruction = rnd;
            if (e.st == 3'd3) begin
                MemAck = (mem_i == w);
                mem_i++;
            end else begin
                MemAck = 1'($urandom_range(0, 1));
            end
            if (i == reset_at) begin
                reset = 1'b1;
                step();
                return;
            end
            step();
            first_m = 1'b0;
            if (i == n - 1 && !halts) ins_m = ins_m + 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vectors++;
        if (act_s !== blank(3'd0)) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", act_s, blank(3'd0));
        end
        vectors++;
        if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_count, instr_count);
        end
        reset   = 1'b0;
        first_m = 1'b1;
    endtask

    task automatic test_add();
        run_instr(6'h00, 6'h20, 0, -1);
        vectors++;
        if (instr_count !== exp_ins()) begin
            errors++;
            $display("FAIL add_instr_count: got %0d expected %0d", instr_count, exp_ins());
        end
    endtask

    task automatic test_lw_wait();
        run_instr(6'h23, 6'($urandom()), 3, -1);
    endtask

    task automatic test_bne();
        run_instr(6'h05, 6'($urandom()), 0, -1);
        run_instr(6'h04, 6'($urandom()), 0, -1);
    endtask

    task automatic test_halt();
        run_instr(6'h3F, 6'($urandom()), 0, -1);
        test_reset();
        run_instr(6'h00, 6'h21, 0, -1);
        test_reset();
    endtask

    task automatic test_sw_reset();
        run_instr(6'h2B, 6'($urandom()), 3, 4);
        vectors++;
        if (act_s !== blank(3'd0)) begin
            errors++;
            $display("FAIL sw_reset_state: got %h expected %h", act_s, blank(3'd0));
        end
        vectors++;
        if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL sw_reset_counters: got %0d/%0d expected 0/0", cycle_count, instr_count);
        end
        reset   = 1'b0;
        first_m = 1'b1;
    endtask

    task automatic test_random();
        logic [5:0] ops[10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h0E, 6'h02, 6'h03};
        logic [5:0] fns[4]  = '{6'h20, 6'h22, 6'h2A, 6'h08};
        int k;
        logic [5:0] fn;
        for (int n = 0; n < 60; n++) begin
            k  = $urandom_range(0, 9);
            fn = (k < 4) ? fns[k] : 6'($urandom());
            if (ops[k] == 6'h05 || n % 7 == 3) run_instr(6'h05, fn, 0, -1);
            else run_instr(ops[k], fn, $urandom_range(0, 3), -1);
        end
    endtask

    initial begin
        reset       = 1'b1;
        Instruction = 32'd0;
        MemAck      = 1'b0;
        test_reset();
        test_add();
        test_lw_wait();
        test_bne();
        test_random();
        test_halt();
        test_sw_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
